// File: rtl/taxi_trip_ctrl.sv
// Taxi meter trip controller: synchronised wheel pulses and 1 s ticks drive a saturating fare.
// Optional NIGHT_SURCHARGE_EN adds a night input (doubled increments, 1.5x start fare).
module taxi_trip_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int START_FARE = 30,
    parameter int KM_PULSES  = 16,
    parameter int WAIT_TICKS = 60,
    parameter int FARE_MAX   = 9999
) (
    input  logic        clk_50MHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        wheel_pulse,
`ifdef NIGHT_SURCHARGE_EN
    input  logic        night,
`endif
    output logic [16:0] fare,
    output logic [1:0]  trip_state,
    output logic        power_on,
    output logic        fare_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(KM_PULSES + 1);
    localparam int WW = $clog2(WAIT_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HIRED  = 2'b01,
        PAUSED = 2'b10,
        SETTLE = 2'b11
    } state_t;

    state_t          state_q;
    logic [16:0]     fare_q;
    logic [PW-1:0]   pulseCnt_q, pulseCnt_d;
    logic [WW-1:0]   waitCnt_q, waitCnt_d;
    logic [TW-1:0]   tickCnt_q, tickCnt_d;
    logic            power_q;
    logic            done_q;
    logic [2:0]      sync_q;
    logic            pulse;
    logic            tick;
    logic            distInc;
    logic            waitInc;
    logic [1:0]      incUnit;
    logic [17:0]     startRaw;
    logic [17:0]     fareSum;
    logic [16:0]     fare_d;
    logic [16:0]     startFare_d;

    // sync_q[2] is a delayed copy of the second stage, used only for edge detection
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], wheel_pulse};
        end
    end

    assign pulse = sync_q[1] & ~sync_q[2];
    assign tick  = (tickCnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        incUnit  = 2'd1;
        startRaw = 18'(START_FARE);
`ifdef NIGHT_SURCHARGE_EN
        if (night) begin
            incUnit  = 2'd2;
            startRaw = 18'(START_FARE + START_FARE / 2);
        end
`endif
        tickCnt_d  = tick ? '0 : tickCnt_q + TW'(1);
        distInc    = 1'b0;
        pulseCnt_d = pulseCnt_q;
        if (pulse) begin
            if (pulseCnt_q == PW'(KM_PULSES - 1)) begin
                pulseCnt_d = '0;
                distInc    = 1'b1;
            end else begin
                pulseCnt_d = pulseCnt_q + PW'(1);
            end
        end
        // A wait window completed on this tick still pays even if a pulse lands in the same cycle
        waitInc   = tick && (waitCnt_q == WW'(WAIT_TICKS - 1));
        waitCnt_d = waitCnt_q;
        if (pulse || waitInc) begin
            waitCnt_d = '0;
        end else if (tick) begin
            waitCnt_d = waitCnt_q + WW'(1);
        end
        fareSum = 18'(fare_q) + (distInc ? 18'(incUnit) : 18'd0) + (waitInc ? 18'(incUnit) : 18'd0);
        fare_d  = (fareSum > 18'(FARE_MAX)) ? 17'(FARE_MAX) : fareSum[16:0];
        startFare_d = (startRaw > 18'(FARE_MAX)) ? 17'(FARE_MAX) : startRaw[16:0];
    end

    // Request priority is stop > pause > start, considering only requests valid in the current state
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fare_q     <= '0;
            pulseCnt_q <= '0;
            waitCnt_q  <= '0;
            tickCnt_q  <= '0;
            power_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    fare_q     <= '0;
                    pulseCnt_q <= '0;
                    waitCnt_q  <= '0;
                    tickCnt_q  <= '0;
                    power_q    <= 1'b0;
                    if (start) begin
                        state_q <= HIRED;
                        fare_q  <= startFare_d;
                        power_q <= 1'b1;
                    end
                end
                HIRED: begin
                    fare_q     <= fare_d;
                    pulseCnt_q <= pulseCnt_d;
                    waitCnt_q  <= waitCnt_d;
                    tickCnt_q  <= tickCnt_d;
                    power_q    <= 1'b1;
                    if (stop) begin
                        state_q <= SETTLE;
                        done_q  <= 1'b1;
                        power_q <= 1'b0;
                    end else if (pause) begin
                        state_q <= PAUSED;
                    end
                end
                PAUSED: begin
                    tickCnt_q <= tickCnt_d;
                    if (tick) begin
                        power_q <= ~power_q;
                    end
                    if (stop) begin
                        state_q <= SETTLE;
                        done_q  <= 1'b1;
                        power_q <= 1'b0;
                    end else if (pause) begin
                        state_q <= HIRED;
                        power_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    tickCnt_q <= '0;
                    power_q   <= 1'b0;
                    if (stop) begin
                        state_q <= IDLE;
                        fare_q  <= '0;
                    end else if (start) begin
                        state_q    <= HIRED;
                        fare_q     <= startFare_d;
                        pulseCnt_q <= '0;
                        waitCnt_q  <= '0;
                        power_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fare       = fare_q;
    assign trip_state = state_q;
    assign power_on   = power_q;
    assign fare_done  = done_q;

endmodule
